// File: rtl/hw5_truth_sweep.sv
// Truth-table sweep engine: walks {x,y,z} through 000..111, holds each
// pattern DWELL cycles, samples f at the end of each hold, then compares
// the captured table against a golden value and pulses done.
module hw5_truth_sweep #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       f,
  input  logic [7:0] expected,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       match,
  output logic [7:0] sweeps
);

  localparam int unsigned CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned TABLE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     pat_q, pat_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [TABLE_W-1:0]   truth_q, truth_d;
  logic                 match_q, match_d;
  logic [TABLE_W-1:0]   sweeps_q, sweeps_d;

  // State and datapath registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      truth_q  <= '0;
      match_q  <= 1'b0;
      sweeps_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      truth_q  <= truth_d;
      match_q  <= match_d;
      sweeps_q <= sweeps_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead
  // so the driven pattern, busy and done all come straight from flops.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pat_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    truth_d  = truth_q;
    match_d  = match_q;
    sweeps_d = sweeps_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          truth_d = '0;
          match_d = 1'b0;
          busy_d  = 1'b1;
          pat_d   = '0;
        end
      end

      S_DRIVE: begin
        busy_d = 1'b1;
        pat_d  = idx_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          truth_d[idx_q] = f;
          if (idx_q == IDX_LAST) begin
            // Bit 7 comes from the live f so match is not one sample stale.
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pat_d    = '0;
            match_d  = ({f, truth_q[6:0]} == expected);
            sweeps_d = sweeps_q + TABLE_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
            pat_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign x      = pat_q[2];
  assign y      = pat_q[1];
  assign z      = pat_q[0];
  assign busy   = busy_q;
  assign done   = done_q;
  assign truth  = truth_q;
  assign match  = match_q;
  assign sweeps = sweeps_q;

endmodule

// File: tb/tb_hw5_truth_sweep.sv
// Bench for hw5_truth_sweep: a DWELL=4 instance for sweep/mismatch/reset
// scenarios and a DWELL=1 instance for back-to-back and counter wrap.
module tb_hw5_truth_sweep;

  logic clk;
  logic rst_n;

  // DWELL=4 instance
  logic       start4, x4, y4, z4, f4, busy4, done4, match4;
  logic [7:0] exp4, truth4, sweeps4;
  logic [7:0] tt4;

  // DWELL=1 instance
  logic       start1, x1, y1, z1, f1, busy1, done1, match1;
  logic [7:0] exp1, truth1, sweeps1;

  int vectors;
  int miscompares;
  logic [7:0] sweeps4_m;
  logic [7:0] sweeps1_m;

  hw5_truth_sweep #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .x(x4), .y(y4), .z(z4), .f(f4), .expected(exp4),
    .busy(busy4), .done(done4), .truth(truth4), .match(match4), .sweeps(sweeps4)
  );

  hw5_truth_sweep #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x(x1), .y(y1), .z(z1), .f(f1), .expected(exp1),
    .busy(busy1), .done(done1), .truth(truth1), .match(match1), .sweeps(sweeps1)
  );

  // Circuits under test: a table-driven one and the fixed (x&y)|~z.
  assign f4 = tt4[{x4, y4, z4}];
  assign f1 = (x1 & y1) | ~z1;

  always #5 clk = ~clk;

  // Truth table of (x&y)|~z computed from the boolean rule itself.
  function automatic logic [7:0] ref_table();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      bit bx, by, bz;
      bx = ((i >> 2) & 1) != 0;
      by = ((i >> 1) & 1) != 0;
      bz = (i & 1) != 0;
      t[i] = (bx && by) || !bz;
    end
    return t;
  endfunction

  // One DWELL=4 sweep checked cycle by cycle; restart_at>=0 re-pulses start mid-sweep.
  task automatic sweep4(input logic [7:0] tt, input logic [7:0] exp_v, input int restart_at);
    int dones;
    logic [2:0] exp_pat;
    logic exp_match;
    dones = 0;
    tt4 = tt;
    exp4 = exp_v;
    exp_match = (tt == exp_v);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 34; c++) begin
      exp_pat = (c < 32) ? 3'(c / 4) : 3'd0;
      vectors++;
      if ({x4, y4, z4} !== exp_pat) begin
        miscompares++;
        $display("FAIL sweep4 pattern c=%0d got %0d want %0d", c, {x4, y4, z4}, exp_pat);
      end
      vectors++;
      if (busy4 !== (c < 32)) begin
        miscompares++;
        $display("FAIL sweep4 busy c=%0d got %0b want %0b", c, busy4, (c < 32));
      end
      vectors++;
      if (done4 !== (c == 32)) begin
        miscompares++;
        $display("FAIL sweep4 done c=%0d got %0b want %0b", c, done4, (c == 32));
      end
      if (done4 === 1'b1) dones++;
      if (c == 32) sweeps4_m = 8'(sweeps4_m + 8'd1);
      if (c >= 32) begin
        vectors++;
        if (truth4 !== tt) begin
          miscompares++;
          $display("FAIL sweep4 truth c=%0d got %h want %h", c, truth4, tt);
        end
        vectors++;
        if (match4 !== exp_match) begin
          miscompares++;
          $display("FAIL sweep4 match c=%0d got %0b want %0b", c, match4, exp_match);
        end
        vectors++;
        if (sweeps4 !== sweeps4_m) begin
          miscompares++;
          $display("FAIL sweep4 sweeps c=%0d got %0d want %0d", c, sweeps4, sweeps4_m);
        end
      end
      start4 = (c == restart_at);
      @(negedge clk);
    end
    start4 = 1'b0;
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL sweep4 done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({x4, y4, z4, busy4, done4, match4, truth4, sweeps4} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset dut4 outputs got %h want 0", {x4, y4, z4, busy4, done4, match4, truth4, sweeps4});
    end
    vectors++;
    if ({x1, y1, z1, busy1, done1, match1, truth1, sweeps1} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset dut1 outputs got %h want 0", {x1, y1, z1, busy1, done1, match1, truth1, sweeps1});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({x4, y4, z4, busy4, done4, match4, truth4, sweeps4} !== 22'd0) begin
        miscompares++;
        $display("FAIL idle dut4 c=%0d got %h want 0", c, {x4, y4, z4, busy4, done4, match4, truth4, sweeps4});
      end
      vectors++;
      if (busy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL idle dut1 busy c=%0d got %0b want 0", c, busy1);
      end
    end
  endtask

  task automatic test_full_sweep();
    sweep4(ref_table(), 8'hD5, -1);
  endtask

  task automatic test_mismatch();
    sweep4(ref_table(), 8'hD4, -1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (truth4 !== 8'hD5 || match4 !== 1'b0 || busy4 !== 1'b0) begin
        miscompares++;
        $display("FAIL mismatch_hold c=%0d got truth=%h match=%0b busy=%0b want D5/0/0", c, truth4, match4, busy4);
      end
    end
  endtask

  task automatic test_start_ignored();
    sweep4(ref_table(), 8'hD5, 10);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] tt, ev;
    for (int n = 0; n < 8; n++) begin
      tt = 8'($urandom);
      case ($urandom_range(0, 2))
        0: ev = tt;
        1: ev = tt ^ 8'h80;
        default: ev = tt ^ 8'(8'd1 << $urandom_range(0, 7));
      endcase
      sweep4(tt, ev, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    tt4 = ref_table();
    exp4 = 8'hD5;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (21) @(negedge clk);
    vectors++;
    if ({x4, y4, z4} !== 3'd5) begin
      miscompares++;
      $display("FAIL reset_mid pre_pattern got %0d want 5", {x4, y4, z4});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({x4, y4, z4, busy4, done4, match4, truth4, sweeps4} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_mid clear got %h want 0", {x4, y4, z4, busy4, done4, match4, truth4, sweeps4});
    end
    sweeps4_m = 8'd0;
    sweeps1_m = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (done4 !== 1'b0 || sweeps4 !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_mid no_done c=%0d got done=%0b sweeps=%0d want 0/0", c, done4, sweeps4);
      end
    end
    sweep4(ref_table(), 8'hD5, -1);
  endtask

  task automatic test_back_to_back();
    int last;
    int k;
    bit exp_done;
    exp1 = 8'hD5;
    last = 8 + 255 * 10;
    start1 = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= last; c++) begin
      exp_done = (c >= 8) && (((c - 8) % 10) == 0);
      vectors++;
      if (done1 !== exp_done) begin
        miscompares++;
        $display("FAIL b2b done c=%0d got %0b want %0b", c, done1, exp_done);
      end
      if (exp_done) begin
        k = (c - 8) / 10 + 1;
        sweeps1_m = 8'(k);
        vectors++;
        if (sweeps1 !== sweeps1_m || truth1 !== 8'hD5 || match1 !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b result k=%0d got sweeps=%0d truth=%h match=%0b want %0d/D5/1", k, sweeps1, truth1, match1, sweeps1_m);
        end
      end
      if (c == last) start1 = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (sweeps1 !== 8'h00 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b wrap got sweeps=%h busy=%0b want 00/0", sweeps1, busy1);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    exp4 = 8'h00;
    exp1 = 8'h00;
    tt4 = 8'h00;
    vectors = 0;
    miscompares = 0;
    sweeps4_m = 8'd0;
    sweeps1_m = 8'd0;
    test_reset();
    test_full_sweep();
    test_mismatch();
    test_start_ignored();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hw5_truth_sweep.md
# hw5_truth_sweep

Synthesizable sweep engine that sits in front of the 3-input combinational circuit under test (F = f(x, y, z)) and collects its output. On `start` it drives x, y, z through all eight combinations in binary order 000 to 111, holding each for DWELL cycles. It samples F on the last cycle of each hold and assembles an 8-bit truth table. It then compares the table against an expected value and pulses `done`.

## Interface
- DWELL, default 4: clock cycles each input pattern is held. Legal range 1..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to begin a sweep; honoured only in IDLE
- x  out  1  MSB of the driven pattern (pattern index bit 2)
- y  out  1  middle bit of the driven pattern (index bit 1)
- z  out  1  LSB of the driven pattern (index bit 0)
- f  in  1  output of the circuit under test
- expected  in  8  golden truth table; bit i = F for index {x,y,z}=i; sampled in the DONE-entry cycle
- busy  out  1  high while the sweep is in progress
- done  out  1  one-cycle pulse when the sweep completes
- truth  out  8  captured truth table; bit i = f sampled at pattern i
- match  out  1  truth == expected; valid from `done` onward
- sweeps  out  8  count of completed sweeps; wraps 255 to 0

## Operation
- States: IDLE, DRIVE, DONE.
- Internal registers:
  - idx (3 bits): pattern index.
  - cnt: dwell counter, width clog2(DWELL), minimum 1 bit.
- IDLE:
  - Outputs: {x,y,z}=000, busy=0, done=0.
  - start=1 moves to DRIVE, with idx=0, cnt=0, truth=0, match=0.
- DRIVE:
  - Outputs: {x,y,z}=idx, busy=1.
  - cnt increments each cycle.
  - When cnt==DWELL-1: truth[idx] <= f, and cnt <= 0.
    - If idx==7, go to DONE. Otherwise idx <= idx+1.
- DONE, one cycle:
  - Outputs: done=1, busy=0, {x,y,z}=000.
  - Always returns to IDLE.
- match is registered on the DRIVE-to-DONE edge. It compares expected against truth with bit 7 replaced by the f value sampled on that same edge, so match is never one sample stale.
- sweeps increments on the DRIVE-to-DONE edge, modulo 256.
- truth and match hold their values through IDLE until the next accepted start. sweeps is never cleared except by reset.
- start is ignored in DRIVE and DONE; it is not queued. start held high continuously gives back-to-back sweeps with exactly one IDLE cycle between them.
- f is assumed settled before the sample edge. With DWELL=1, f is sampled on the same cycle the pattern is applied, which only suits a zero-delay circuit under test.

## Timing
- Reset (asynchronous, immediate):
  - State=IDLE, idx=0, cnt=0.
  - x=y=z=0, busy=0, done=0, truth=8'h00, match=0, sweeps=8'h00.
- Reset asserted mid-sweep aborts immediately. The partial truth table is discarded. No done pulse and no sweeps increment occur.
- start sampled high at edge E:
  - From E: busy=1 and pattern 0 is driven.
  - Pattern i is driven on cycles E+i·DWELL through E+(i+1)·DWELL−1.
  - f for pattern i is captured at edge E+(i+1)·DWELL.
- At edge E+8·DWELL: busy falls, done rises, and truth, match and sweeps update.
- At edge E+8·DWELL+1: done falls and the block is back in IDLE. The earliest next accepted start is at edge E+8·DWELL+2.
- Total latency from start edge to done: 8·DWELL cycles (32 at the default).
- Pattern index wraps only by ending the sweep. idx never wraps from 7 to 0 inside DRIVE.

## Test plan
- Reset check: hold rst_n=0, then release. All outputs are 0. start=0 for 10 cycles leaves outputs unchanged and busy=0.
- Full sweep, DWELL=4:
  - Model f = (x&y)|~z, expected=8'hD5, pulse start.
  - {x,y,z} steps 000 to 111, each held exactly 4 cycles.
  - done pulses exactly 32 cycles after the start edge.
  - truth=8'hD5, match=1, sweeps=1.
- Mismatch: same f model, expected=8'hD4. truth=8'hD5, match=0. truth and match then hold through 20 IDLE cycles.
- start ignored while busy: pulse start again at cycle 10 of a sweep. Completion timing is unchanged, there is only one done pulse, and sweeps increments by exactly 1.
- Reset mid-sweep: drop rst_n during pattern 5. Outputs clear immediately and there is no done pulse. A new start then completes normally with sweeps=1.
- Back-to-back and wrap:
  - DWELL=1 with start held high: done pulses every 10 cycles.
  - After 256 sweeps, sweeps reads 8'h00.
